// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, default opcodes and the
// all-ones BYPASS decode rule used by every block on the JTAG path.
package jtag_pkg;

  localparam logic [3:0] TLR    = 4'd0;
  localparam logic [3:0] RTI    = 4'd1;
  localparam logic [3:0] SEL_DR = 4'd2;
  localparam logic [3:0] CAP_DR = 4'd3;
  localparam logic [3:0] SH_DR  = 4'd4;
  localparam logic [3:0] EX1_DR = 4'd5;
  localparam logic [3:0] PA_DR  = 4'd6;
  localparam logic [3:0] EX2_DR = 4'd7;
  localparam logic [3:0] UPD_DR = 4'd8;
  localparam logic [3:0] SEL_IR = 4'd9;
  localparam logic [3:0] CAP_IR = 4'd10;
  localparam logic [3:0] SH_IR  = 4'd11;
  localparam logic [3:0] EX1_IR = 4'd12;
  localparam logic [3:0] PA_IR  = 4'd13;
  localparam logic [3:0] EX2_IR = 4'd14;
  localparam logic [3:0] UPD_IR = 4'd15;

  localparam logic [3:0] DEFAULT_IDCODE_OPCODE = 4'h1;
  localparam logic [3:0] DEFAULT_USER_OPCODE   = 4'h8;

  typedef enum logic [1:0] {
    INSTR_BYPASS = 2'd0,
    INSTR_IDCODE = 2'd1,
    INSTR_USER   = 2'd2
  } instr_e;

  // True when the low w bits of v are all ones (the BYPASS opcode).
  function automatic logic is_all_ones(input logic [7:0] v, input int unsigned w);
    logic ones;
    ones = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < w && !v[i]) ones = 1'b0;
    end
    return ones;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; exposes current and next state so the
// core can act on Test_logic_reset entry in the same edge.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCLK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] STATE,
  output logic [3:0] next_state
);

  logic [3:0] state_q;

  always_comb begin
    next_state = TLR;
    case (state_q)
      TLR:     next_state = TMS ? TLR    : RTI;
      RTI:     next_state = TMS ? SEL_DR : RTI;
      SEL_DR:  next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  next_state = TMS ? EX1_DR : SH_DR;
      SH_DR:   next_state = TMS ? EX1_DR : SH_DR;
      EX1_DR:  next_state = TMS ? UPD_DR : PA_DR;
      PA_DR:   next_state = TMS ? EX2_DR : PA_DR;
      EX2_DR:  next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR:  next_state = TMS ? SEL_DR : RTI;
      SEL_IR:  next_state = TMS ? TLR    : CAP_IR;
      CAP_IR:  next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:   next_state = TMS ? EX1_IR : SH_IR;
      EX1_IR:  next_state = TMS ? UPD_IR : PA_IR;
      PA_IR:   next_state = TMS ? EX2_IR : PA_IR;
      EX2_IR:  next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR:  next_state = TMS ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) state_q <= TLR;
    else      state_q <= next_state;
  end

  assign STATE = state_q;

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG test access port: TAP controller, instruction register, BYPASS and
// IDCODE data registers, falling-edge TDO retiming and user DR strobes.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH      = 4,
  parameter logic [31:0]          IDCODE_VALUE  = 32'h1234_5677,
  parameter logic [IR_WIDTH-1:0]  IDCODE_OPCODE = IR_WIDTH'(DEFAULT_IDCODE_OPCODE),
  parameter logic [IR_WIDTH-1:0]  USER_OPCODE   = IR_WIDTH'(DEFAULT_USER_OPCODE)
) (
  input  logic                TCLK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          STATE,
  output logic [IR_WIDTH-1:0] IR,
  output logic                USER_SEL,
  output logic                USER_CAPTURE,
  output logic                USER_SHIFT,
  output logic                USER_UPDATE,
  input  logic                USER_TDO
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic [3:0]          state;
  logic [3:0]          state_d;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_q;
  logic                bypass_q;
  logic [31:0]         idcode_q;
  logic                dr_tdo;
  logic                tdo_q;
  logic                tdo_en_q;
  instr_e              instr;

  tap_fsm u_fsm (
    .TCLK       (TCLK),
    .TRST       (TRST),
    .TMS        (TMS),
    .STATE      (state),
    .next_state (state_d)
  );

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      ir_sr <= IR_CAPTURE;
    end else if (state == CAP_IR) begin
      ir_sr <= IR_CAPTURE;
    end else if (state == SH_IR) begin
      ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
    end
  end

  // Entering Test_logic_reset by TMS restores IDCODE on that same edge.
  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      ir_q <= IDCODE_OPCODE;
    end else if (state_d == TLR) begin
      ir_q <= IDCODE_OPCODE;
    end else if (state == UPD_IR) begin
      ir_q <= ir_sr;
    end
  end

  always_comb begin
    instr = INSTR_BYPASS;
    if (is_all_ones(8'(ir_q), IR_WIDTH)) instr = INSTR_BYPASS;
    else if (ir_q == IDCODE_OPCODE)      instr = INSTR_IDCODE;
    else if (ir_q == USER_OPCODE)        instr = INSTR_USER;
  end

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      bypass_q <= 1'b0;
    end else if (instr == INSTR_BYPASS) begin
      if (state == CAP_DR)     bypass_q <= 1'b0;
      else if (state == SH_DR) bypass_q <= TDI;
    end
  end

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      idcode_q <= IDCODE_VALUE;
    end else if (instr == INSTR_IDCODE) begin
      if (state == CAP_DR)     idcode_q <= IDCODE_VALUE;
      else if (state == SH_DR) idcode_q <= {TDI, idcode_q[31:1]};
    end
  end

  always_comb begin
    dr_tdo = bypass_q;
    case (instr)
      INSTR_IDCODE: dr_tdo = idcode_q[0];
      INSTR_USER:   dr_tdo = USER_TDO;
      default:      dr_tdo = bypass_q;
    endcase
  end

  // TDO is valid only while TDO_EN is high; both retimed to the falling edge.
  always_ff @(negedge TCLK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= (state == SH_DR) || (state == SH_IR);
      if (state == SH_IR)      tdo_q <= ir_sr[0];
      else if (state == SH_DR) tdo_q <= dr_tdo;
      else                     tdo_q <= 1'b0;
    end
  end

  assign TDO          = tdo_q;
  assign TDO_EN       = tdo_en_q;
  assign STATE        = state;
  assign IR           = ir_q;
  assign USER_SEL     = (instr == INSTR_USER);
  assign USER_CAPTURE = USER_SEL && (state == CAP_DR);
  assign USER_SHIFT   = USER_SEL && (state == SH_DR);
  assign USER_UPDATE  = USER_SEL && (state == UPD_DR);

endmodule

// File: tb/tb_jtag_tap_core.sv
// Directed bench for jtag_tap_core: expected TDO bits are queued by the
// stimulus and consumed by a falling-edge monitor whenever TDO_EN is high.
module tb_jtag_tap_core;

  localparam int IRW = 4;

  logic           TCLK;
  logic           TRST;
  logic           TMS;
  logic           TDI;
  logic           TDO;
  logic           TDO_EN;
  logic [3:0]     STATE;
  logic [IRW-1:0] IR;
  logic           USER_SEL;
  logic           USER_CAPTURE;
  logic           USER_SHIFT;
  logic           USER_UPDATE;
  logic           USER_TDO;

  logic [0:0] exp_q[$];
  int n_chk;
  int n_pass;
  int cap_cnt;
  int sh_cnt;
  int upd_cnt;
  int usel_cnt;
  logic [IRW-1:0] cur_ir;

  jtag_tap_core dut (
    .TCLK         (TCLK),
    .TRST         (TRST),
    .TMS          (TMS),
    .TDI          (TDI),
    .TDO          (TDO),
    .TDO_EN       (TDO_EN),
    .STATE        (STATE),
    .IR           (IR),
    .USER_SEL     (USER_SEL),
    .USER_CAPTURE (USER_CAPTURE),
    .USER_SHIFT   (USER_SHIFT),
    .USER_UPDATE  (USER_UPDATE),
    .USER_TDO     (USER_TDO)
  );

  // clock / reset
  initial TCLK = 1'b0;
  always #5 TCLK = ~TCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
  endtask

  // monitor / scoreboard
  always @(negedge TCLK) begin
    logic [0:0] e;
    #1;
    if (USER_CAPTURE) cap_cnt++;
    if (USER_SHIFT)   sh_cnt++;
    if (USER_UPDATE)  upd_cnt++;
    if (USER_SEL)     usel_cnt++;
    if (TDO_EN) begin
      if (exp_q.size() == 0) begin
        check("tdo_unexpected", 32'(TDO_EN), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tdo_bit", 32'(TDO), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic tick(input logic tms, input logic tdi, input logic utdo);
    TMS = tms;
    TDI = tdi;
    USER_TDO = utdo;
    @(posedge TCLK);
    #1;
  endtask

  task automatic scan_ir(input logic [IRW-1:0] tdi);
    for (int i = 0; i < IRW; i++) exp_q.push_back(i == 0 ? 1'b1 : 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("cap_ir_state", 32'(STATE), 32'd10);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < IRW; i++) tick(i == IRW - 1, tdi[i], 1'b0);
    check("ex1_ir_state", 32'(STATE), 32'd12);
    tick(1'b1, 1'b0, 1'b0);
    check("upd_ir_state", 32'(STATE), 32'd15);
    check("ir_held_in_upd", 32'(IR), 32'(cur_ir));
    tick(1'b0, 1'b0, 1'b0);
    cur_ir = tdi;
    check("ir_after_update", 32'(IR), 32'(tdi));
    check("rti_after_ir", 32'(STATE), 32'd1);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] tdi, input logic [63:0] utdo,
                         input logic [63:0] exp);
    for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("cap_dr_state", 32'(STATE), 32'd3);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick(i == n - 1, tdi[i], utdo[i]);
    check("ex1_dr_state", 32'(STATE), 32'd5);
    tick(1'b1, 1'b0, 1'b0);
    check("upd_dr_state", 32'(STATE), 32'd8);
    tick(1'b0, 1'b0, 1'b0);
    check("rti_after_dr", 32'(STATE), 32'd1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    cap_cnt = 0; sh_cnt = 0; upd_cnt = 0; usel_cnt = 0;
    TRST = 1'b1; TMS = 1'b0; TDI = 1'b0; USER_TDO = 1'b0;
    cur_ir = 4'h1;
    #12;
    check("rst_state", 32'(STATE), 32'd0);
    check("rst_ir", 32'(IR), 32'h1);
    check("rst_tdo", 32'(TDO), 32'd0);
    check("rst_tdo_en", 32'(TDO_EN), 32'd0);
    check("rst_user", 32'({USER_SEL, USER_CAPTURE, USER_SHIFT, USER_UPDATE}), 32'd0);
    #10;
    TRST = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check("first_rti", 32'(STATE), 32'd1);

    // IDCODE after reset, then the shifted-in zeros
    scan_dr(64, 64'd0, 64'd0, {32'd0, 32'h1234_5677});

    // BYPASS with 1,1,0,1 in gives 0,1,1,0 out
    scan_ir(4'hF);
    check("bypass_usel", 32'(USER_SEL), 32'd0);
    scan_dr(4, 64'b1011, 64'd0, 64'b0110);

    // USER register path
    scan_ir(4'h8);
    check("user_sel", 32'(USER_SEL), 32'd1);
    cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
    scan_dr(8, 64'hFF, 64'b0110_1001, 64'b0110_1001);
    check("user_capture_cycles", 32'(cap_cnt), 32'd1);
    check("user_shift_cycles", 32'(sh_cnt), 32'd8);
    check("user_update_cycles", 32'(upd_cnt), 32'd1);

    // undefined opcode acts as BYPASS: 1,0,1,0 in gives 0,1,0,1 out
    scan_ir(4'h5);
    usel_cnt = 0; sh_cnt = 0;
    scan_dr(4, 64'b0101, 64'hF, 64'b1010);
    check("undef_usel_cycles", 32'(usel_cnt), 32'd0);
    check("undef_user_shift", 32'(sh_cnt), 32'd0);

    // TRST pulse in the middle of Shift_DR
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("mid_shift_state", 32'(STATE), 32'd4);
    TRST = 1'b1;
    #1;
    check("trst_state", 32'(STATE), 32'd0);
    check("trst_ir", 32'(IR), 32'h1);
    @(negedge TCLK);
    #1;
    check("trst_tdo_en", 32'(TDO_EN), 32'd0);
    TRST = 1'b0;
    cur_ir = 4'h1;
    tick(1'b0, 1'b0, 1'b0);
    check("post_trst_rti", 32'(STATE), 32'd1);

    // TMS-driven reset from Pause_IR restores IDCODE
    scan_ir(4'hF);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("pause_ir_state", 32'(STATE), 32'd13);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    check("four_tms_not_reset", 32'(STATE == 4'd0), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("tms_reset_state", 32'(STATE), 32'd0);
    check("tms_reset_ir", 32'(IR), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    check("tms_reset_rti", 32'(STATE), 32'd1);
    cur_ir = 4'h1;

    // IDCODE recaptured regardless of TDI pattern
    scan_dr(32, 64'hA5A5_A5A5, 64'd0, 64'h1234_5677);

    tick(1'b0, 1'b0, 1'b0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
